// File: rtl/mvm_pkg.sv
// Shared types and default widths for the MVM job scheduler: descriptor layout,
// scheduler FSM encoding and the saturating cycle-count helper.
package mvm_pkg;

  localparam int VEC_ADDRW_DEF = 4;
  localparam int MAT_ADDRW_DEF = 5;
  localparam int QDEPTH_DEF    = 4;
  localparam int IDW_DEF       = 2;
  localparam int CYCW          = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_RETIRE    = 3'd4
  } sched_state_t;

  // Descriptor as stored in the job queue at the default widths (MSB first).
  typedef struct packed {
    logic [IDW_DEF-1:0]     id;
    logic [MAT_ADDRW_DEF:0]   mat_rows;
    logic [MAT_ADDRW_DEF-1:0] mat_start;
    logic [VEC_ADDRW_DEF:0]   vec_words;
    logic [VEC_ADDRW_DEF-1:0] vec_start;
  } job_desc_t;

  function automatic logic [CYCW-1:0] sat_inc(input logic [CYCW-1:0] v);
    return (v == {CYCW{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mvm_job_fifo.sv
// Synchronous job-descriptor FIFO with registered occupancy count and
// show-ahead read data (head is visible whenever the FIFO is non-empty).
module mvm_job_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DW-1:0]              wdata_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign push_ok = push_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mvm_job_sched.sv
// MVM job scheduler: queues job descriptors, launches them one at a time on the
// ctrl block and retires them. Define MVM_SCHED_CYCCNT_EN to enable done_cycles.
module mvm_job_sched
  import mvm_pkg::*;
#(
  parameter int VEC_ADDRW = VEC_ADDRW_DEF,
  parameter int MAT_ADDRW = MAT_ADDRW_DEF,
  parameter int QDEPTH    = QDEPTH_DEF,
  parameter int IDW       = IDW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [VEC_ADDRW-1:0]     job_vec_start,
  input  logic [VEC_ADDRW:0]       job_vec_words,
  input  logic [MAT_ADDRW-1:0]     job_mat_start,
  input  logic [MAT_ADDRW:0]       job_mat_rows,
  output logic [IDW-1:0]           job_id,
  output logic                     ctrl_start,
  output logic [VEC_ADDRW-1:0]     ctrl_vec_start_addr,
  output logic [VEC_ADDRW:0]       ctrl_vec_num_words,
  output logic [MAT_ADDRW-1:0]     ctrl_mat_start_addr,
  output logic [MAT_ADDRW:0]       ctrl_mat_num_rows_per_olane,
  input  logic                     ctrl_busy,
  output logic                     done_valid,
  input  logic                     done_ready,
  output logic [IDW-1:0]           done_id,
  output logic                     done_err,
  output logic [15:0]              done_cycles,
  output logic [$clog2(QDEPTH):0]  queue_count,
  output logic [2:0]               dbg_state
);

  localparam int CNTW = $clog2(QDEPTH) + 1;
  localparam int DW   = IDW + (MAT_ADDRW + 1) + MAT_ADDRW + (VEC_ADDRW + 1) + VEC_ADDRW;

  // Handshakes: a transfer happens on a cycle where valid && ready; valid,
  // once raised, holds its payload stable until that transfer completes.
  logic                 push, pop, fifo_empty;
  logic [DW-1:0]        fifo_wdata, fifo_rdata;
  logic [IDW-1:0]       h_id;
  logic [MAT_ADDRW:0]   h_mat_rows;
  logic [MAT_ADDRW-1:0] h_mat_start;
  logic [VEC_ADDRW:0]   h_vec_words;
  logic [VEC_ADDRW-1:0] h_vec_start;
  logic                 h_zero;

  logic [IDW-1:0]       id_q, id_d;
  sched_state_t         state_q;
  logic [VEC_ADDRW-1:0] vec_start_q;
  logic [VEC_ADDRW:0]   vec_words_q;
  logic [MAT_ADDRW-1:0] mat_start_q;
  logic [MAT_ADDRW:0]   mat_rows_q;
  logic [IDW-1:0]       act_id_q;
  logic                 err_q, start_q, done_valid_q;

  assign job_ready  = (queue_count < CNTW'(QDEPTH));
  assign push       = job_valid && job_ready;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign fifo_wdata = {id_q, job_mat_rows, job_mat_start, job_vec_words, job_vec_start};
  assign {h_id, h_mat_rows, h_mat_start, h_vec_words, h_vec_start} = fifo_rdata;
  assign h_zero     = (h_vec_words == '0) || (h_mat_rows == '0);
  assign id_d       = push ? id_q + 1'b1 : id_q;

  mvm_job_fifo #(.DW(DW), .DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (queue_count)
  );

  always_ff @(posedge clk) begin
    if (rst) id_q <= '0;
    else     id_q <= id_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_start_q  <= '0;
      vec_words_q  <= '0;
      mat_start_q  <= '0;
      mat_rows_q   <= '0;
      act_id_q     <= '0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      done_valid_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            vec_start_q <= h_vec_start;
            vec_words_q <= h_vec_words;
            mat_start_q <= h_mat_start;
            mat_rows_q  <= h_mat_rows;
            act_id_q    <= h_id;
            err_q       <= h_zero;
            // Zero-size jobs are rejected without ever touching ctrl.
            if (h_zero) begin
              state_q      <= S_RETIRE;
              done_valid_q <= 1'b1;
            end else begin
              state_q <= S_LAUNCH;
              start_q <= 1'b1;
            end
          end
        end
        S_LAUNCH:    state_q <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (ctrl_busy) state_q <= S_RUN;
        S_RUN: begin
          if (!ctrl_busy) begin
            state_q      <= S_RETIRE;
            done_valid_q <= 1'b1;
          end
        end
        S_RETIRE: begin
          if (done_ready) begin
            state_q      <= S_IDLE;
            done_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MVM_SCHED_CYCCNT_EN
  // Counts 1 in LAUNCH and keeps counting until the cycle RETIRE is entered.
  logic [CYCW-1:0] cyc_q;
  always_ff @(posedge clk) begin
    if (rst)
      cyc_q <= '0;
    else if (pop)
      cyc_q <= h_zero ? '0 : CYCW'(1);
    else if (state_q inside {S_LAUNCH, S_WAIT_BUSY, S_RUN})
      cyc_q <= sat_inc(cyc_q);
  end
  assign done_cycles = cyc_q;
`else
  assign done_cycles = '0;
`endif

  assign job_id                      = id_q;
  assign ctrl_start                  = start_q;
  assign ctrl_vec_start_addr         = vec_start_q;
  assign ctrl_vec_num_words          = vec_words_q;
  assign ctrl_mat_start_addr         = mat_start_q;
  assign ctrl_mat_num_rows_per_olane = mat_rows_q;
  assign done_valid                  = done_valid_q;
  assign done_id                     = act_id_q;
  assign done_err                    = err_q;
  assign dbg_state                   = state_q;

endmodule
